// File: rtl/bip1_run_ctrl_if.sv
// Command, CPU-side, data-memory and dump-byte signals of the BIP1 run controller.
// The controller attaches through the slave modport; host/CPU/memory side uses master.
interface bip1_run_ctrl_if #(
  parameter int unsigned NB_OPCODE = 5,
  parameter int unsigned NB_ADDR   = 11,
  parameter int unsigned NB_DATA   = 16,
  parameter int unsigned NB_CYCLES = 16
);
  logic                 i_cmd_valid;
  logic [1:0]           i_cmd;
  logic                 o_cmd_ready;
  logic [NB_OPCODE-1:0] i_opcode;
  logic                 o_cpu_en;
  logic                 o_cpu_clr;
  logic [NB_ADDR-1:0]   i_cpu_addr;
  logic                 i_cpu_wr_en;
  logic                 i_cpu_rd_en;
  logic [NB_ADDR-1:0]   o_mem_addr;
  logic                 o_mem_wr_en;
  logic                 o_mem_rd_en;
  logic [NB_DATA-1:0]   i_mem_data;
  logic [7:0]           o_tx_data;
  logic                 o_tx_valid;
  logic                 i_tx_ready;
  logic [NB_CYCLES-1:0] o_cycle_count;
  logic                 o_halted;
  logic                 o_busy;

  modport master (
    output i_cmd_valid, i_cmd, i_opcode, i_cpu_addr, i_cpu_wr_en, i_cpu_rd_en,
           i_mem_data, i_tx_ready,
    input  o_cmd_ready, o_cpu_en, o_cpu_clr, o_mem_addr, o_mem_wr_en, o_mem_rd_en,
           o_tx_data, o_tx_valid, o_cycle_count, o_halted, o_busy
  );

  modport slave (
    input  i_cmd_valid, i_cmd, i_opcode, i_cpu_addr, i_cpu_wr_en, i_cpu_rd_en,
           i_mem_data, i_tx_ready,
    output o_cmd_ready, o_cpu_en, o_cpu_clr, o_mem_addr, o_mem_wr_en, o_mem_rd_en,
           o_tx_data, o_tx_valid, o_cycle_count, o_halted, o_busy
  );
endinterface

// File: rtl/bip1_run_ctrl.sv
// BIP1 run/step controller: gates the CPU, detects HLT, counts executed
// instructions and streams the low data-memory words out as bytes.
module bip1_run_ctrl #(
  parameter int unsigned NB_OPCODE  = 5,
  parameter int unsigned NB_ADDR    = 11,
  parameter int unsigned NB_DATA    = 16,
  parameter int unsigned NB_CYCLES  = 16,
  parameter int unsigned DUMP_WORDS = 16
) (
  input logic            i_clk,
  input logic            i_rst,
  bip1_run_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALTED,
    ST_DUMP_RD,
    ST_DUMP_WAIT,
    ST_DUMP_HI,
    ST_DUMP_LO
  } state_t;

  typedef enum logic [1:0] {
    CMD_RUN   = 2'b00,
    CMD_STEP  = 2'b01,
    CMD_DUMP  = 2'b10,
    CMD_ABORT = 2'b11
  } cmd_t;

  localparam logic [NB_OPCODE-1:0] OP_HLT   = '0;
  localparam logic [NB_ADDR-1:0]   LAST_IDX = NB_ADDR'(DUMP_WORDS - 1);

  state_t state_q, state_d;
  state_t ret_q, ret_d;
  cmd_t   cmd;

  logic                 cmd_ready, accept, is_hlt, in_dump;
  logic                 cpu_en, busy;
  logic                 step_q, step_d;
  logic                 clr_q, clr_d;
  logic                 halted_q, halt_set, halt_clr;
  logic [NB_CYCLES-1:0] cnt_q;
  logic                 cnt_clr;
  logic [NB_ADDR-1:0]   idx_q;
  logic                 idx_inc, idx_clr;
  logic                 tx_valid_q;
  logic [7:0]           tx_data_q, lo_q;
  logic                 load_word, send_lo, drop_tx;

  assign cmd       = cmd_t'(bus.i_cmd);
  assign is_hlt    = (bus.i_opcode == OP_HLT);
  assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_HALTED);
  assign accept    = bus.i_cmd_valid && cmd_ready;
  assign in_dump   = !cmd_ready;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      ret_q   <= ST_IDLE;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    cpu_en    = 1'b0;
    busy      = 1'b0;
    step_d    = 1'b0;
    clr_d     = 1'b0;
    halt_set  = 1'b0;
    halt_clr  = 1'b0;
    cnt_clr   = 1'b0;
    idx_inc   = 1'b0;
    idx_clr   = 1'b0;
    load_word = 1'b0;
    send_lo   = 1'b0;
    drop_tx   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A step request becomes an enable pulse in the cycle after acceptance
        cpu_en = step_q;
        if (accept) begin
          case (cmd)
            CMD_RUN:  state_d = ST_RUN;
            CMD_STEP: begin
              if (is_hlt) begin
                state_d  = ST_HALTED;
                halt_set = 1'b1;
              end else begin
                step_d = 1'b1;
              end
            end
            CMD_DUMP: begin
              state_d = ST_DUMP_RD;
              ret_d   = ST_IDLE;
            end
            CMD_ABORT: begin
              clr_d   = 1'b1;
              cnt_clr = 1'b1;
            end
          endcase
        end
      end

      ST_RUN: begin
        busy   = 1'b1;
        cpu_en = !is_hlt;
        // ABORT takes priority over a simultaneous HLT
        if (accept && cmd == CMD_ABORT) begin
          state_d = ST_IDLE;
        end else if (is_hlt) begin
          state_d  = ST_HALTED;
          halt_set = 1'b1;
        end
      end

      ST_HALTED: begin
        if (accept && cmd == CMD_DUMP) begin
          state_d = ST_DUMP_RD;
          ret_d   = ST_HALTED;
        end else if (accept && cmd == CMD_ABORT) begin
          state_d  = ST_IDLE;
          clr_d    = 1'b1;
          cnt_clr  = 1'b1;
          halt_clr = 1'b1;
        end
      end

      ST_DUMP_RD: begin
        busy    = 1'b1;
        state_d = ST_DUMP_WAIT;
      end

      ST_DUMP_WAIT: begin
        busy      = 1'b1;
        load_word = 1'b1;
        state_d   = ST_DUMP_HI;
      end

      ST_DUMP_HI: begin
        busy = 1'b1;
        if (bus.i_tx_ready) begin
          send_lo = 1'b1;
          state_d = ST_DUMP_LO;
        end
      end

      ST_DUMP_LO: begin
        busy = 1'b1;
        if (bus.i_tx_ready) begin
          drop_tx = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_clr = 1'b1;
            state_d = ret_q;
          end else begin
            idx_inc = 1'b1;
            state_d = ST_DUMP_RD;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      step_q     <= 1'b0;
      clr_q      <= 1'b0;
      halted_q   <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      lo_q       <= '0;
    end else begin
      step_q <= step_d;
      clr_q  <= clr_d;

      if (halt_clr) begin
        halted_q <= 1'b0;
      end else if (halt_set) begin
        halted_q <= 1'b1;
      end

      // Clear beats a same-cycle step increment; the count sticks at all-ones
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cpu_en && cnt_q != '1) begin
        cnt_q <= cnt_q + NB_CYCLES'(1);
      end

      if (idx_clr) begin
        idx_q <= '0;
      end else if (idx_inc) begin
        idx_q <= idx_q + NB_ADDR'(1);
      end

      // Low byte is parked so the high byte can be held stable under backpressure
      if (load_word) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= bus.i_mem_data[NB_DATA-1 -: 8];
        lo_q       <= bus.i_mem_data[7:0];
      end else if (send_lo) begin
        tx_data_q <= lo_q;
      end else if (drop_tx) begin
        tx_valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_cmd_ready   = cmd_ready;
  assign bus.o_cpu_en      = cpu_en;
  assign bus.o_cpu_clr     = clr_q;
  assign bus.o_cycle_count = cnt_q;
  assign bus.o_halted      = halted_q;
  assign bus.o_busy        = busy;
  assign bus.o_tx_valid    = tx_valid_q;
  assign bus.o_tx_data     = tx_data_q;
  assign bus.o_mem_addr    = in_dump ? idx_q : bus.i_cpu_addr;
  assign bus.o_mem_rd_en   = in_dump ? (state_q == ST_DUMP_RD) : (bus.i_cpu_rd_en && cpu_en);
  assign bus.o_mem_wr_en   = !in_dump && bus.i_cpu_wr_en && cpu_en;

endmodule
